// File: rtl/rgb_box_blur_3x3.sv
// Streaming 3x3 box blur for 24-bit RGB rasters with edge replication.
// Two line buffers hold the previous two rows; a 3-column window of column sums feeds the divider.
module rgb_box_blur_3x3 #(
  parameter int MAX_WIDTH  = 1080,
  parameter int MAX_HEIGHT = 1080
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [11:0] WIDTH,
  input  logic [11:0] HEIGHT,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [7:0]  IN_R,
  input  logic [7:0]  IN_G,
  input  logic [7:0]  IN_B,
  output logic        OUT_VALID,
  output logic [11:0] OUT_ROW,
  output logic [11:0] OUT_COL,
  output logic [7:0]  OUT_R,
  output logic [7:0]  OUT_G,
  output logic [7:0]  OUT_B,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        CFG_ERR
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [11:0] MAX_W = 12'(MAX_WIDTH);
  localparam logic [11:0] MAX_H = 12'(MAX_HEIGHT);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_COLFIX, S_FLUSH, S_DONE} state_t;
  typedef logic [2:0][7:0] pix_t;   // [2]=R [1]=G [0]=B
  typedef logic [2:0][9:0] csum_t;  // per-channel sum of one 3-row column

  state_t      state_q, state_d;
  logic [11:0] w_q, w_d, h_q, h_d;
  logic [11:0] row_q, row_d, col_q, col_d, fcol_q, fcol_d;
  csum_t       cs_a_q, cs_a_d, cs_b_q, cs_b_d;
  logic        err_q, err_d, ov_q, ov_d;
  logic [11:0] orow_q, orow_d, ocol_q, ocol_d;
  pix_t        opix_q, opix_d;

  pix_t lb0_mem [MAX_WIDTH];  // row i-2
  pix_t lb1_mem [MAX_WIDTH];  // row i-1

  logic [AW-1:0] rd_addr;
  pix_t          in_px, top_px, mid_px;
  csum_t         run_cs, flush_cs, op_a, op_b, op_c;
  logic          accept, legal;

  assign in_px  = {IN_R, IN_G, IN_B};
  assign accept = (state_q == S_RUN) && IN_VALID;
  assign legal  = (WIDTH >= 12'd3) && (WIDTH <= MAX_W) &&
                  (HEIGHT >= 12'd3) && (HEIGHT <= MAX_H);

  // COLFIX preloads column 0 for the flush; FLUSH reads one column ahead of its output.
  always_comb begin
    rd_addr = AW'(col_q);
    if (state_q == S_COLFIX)
      rd_addr = '0;
    else if (state_q == S_FLUSH)
      rd_addr = (fcol_q == w_q - 12'd1) ? AW'(fcol_q) : AW'(fcol_q + 12'd1);
  end

  assign top_px = lb0_mem[rd_addr];
  assign mid_px = lb1_mem[rd_addr];

  // Row 1 has no row above; replicate row 0 into the top tap.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      run_cs[ch]   = 10'((row_q == 12'd1) ? mid_px[ch] : top_px[ch]) +
                     10'(mid_px[ch]) + 10'(in_px[ch]);
      flush_cs[ch] = 10'(top_px[ch]) + 10'({mid_px[ch], 1'b0});
    end
  end

  always_comb begin
    logic [11:0] sum;
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    fcol_d  = fcol_q;
    cs_a_d  = cs_a_q;
    cs_b_d  = cs_b_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    opix_d  = opix_q;
    op_a    = cs_a_q;
    op_b    = cs_a_q;
    op_c    = cs_a_q;
    sum     = '0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (legal) begin
            w_d     = WIDTH;
            h_d     = HEIGHT;
            row_d   = '0;
            col_d   = '0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (IN_VALID) begin
          cs_b_d = cs_a_q;
          cs_a_d = run_cs;
          op_a   = (col_q == 12'd1) ? cs_a_q : cs_b_q;  // left edge replicates col 0
          op_c   = run_cs;
          if (row_q != '0 && col_q != '0) begin
            ov_d   = 1'b1;
            orow_d = row_q - 12'd1;
            ocol_d = col_q - 12'd1;
          end
          if (col_q == w_q - 12'd1) begin
            col_d = '0;
            if (row_q == '0) row_d = 12'd1;
            else             state_d = S_COLFIX;
          end else begin
            col_d = col_q + 12'd1;
          end
        end
      end
      S_COLFIX: begin
        ov_d   = 1'b1;
        orow_d = row_q - 12'd1;
        ocol_d = w_q - 12'd1;
        op_a   = cs_b_q;
        if (row_q == h_q - 12'd1) begin
          state_d = S_FLUSH;
          fcol_d  = '0;
          cs_a_d  = flush_cs;
        end else begin
          row_d   = row_q + 12'd1;
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        ov_d   = 1'b1;
        orow_d = h_q - 12'd1;
        ocol_d = fcol_q;
        op_a   = (fcol_q == '0) ? cs_a_q : cs_b_q;
        op_c   = flush_cs;
        cs_b_d = cs_a_q;
        cs_a_d = flush_cs;
        if (fcol_q == w_q - 12'd1) state_d = S_DONE;
        else                       fcol_d  = fcol_q + 12'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ov_d) begin
      for (int ch = 0; ch < 3; ch++) begin
        sum        = 12'(op_a[ch]) + 12'(op_b[ch]) + 12'(op_c[ch]);
        opix_d[ch] = 8'((sum + 12'd4) / 12'd9);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fcol_q  <= '0;
      cs_a_q  <= '0;
      cs_b_q  <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      opix_q  <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fcol_q  <= fcol_d;
      cs_a_q  <= cs_a_d;
      cs_b_q  <= cs_b_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      opix_q  <= opix_d;
    end
  end

  // Line buffers are never cleared; unread entries are masked by the row/col logic.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb0_mem[rd_addr] <= lb1_mem[rd_addr];
      lb1_mem[rd_addr] <= in_px;
    end
  end

  assign IN_READY   = (state_q == S_RUN);
  assign BUSY       = (state_q == S_RUN) || (state_q == S_COLFIX) || (state_q == S_FLUSH);
  assign FRAME_DONE = (state_q == S_DONE);
  assign CFG_ERR    = err_q;
  assign OUT_VALID  = ov_q;
  assign OUT_ROW    = orow_q;
  assign OUT_COL    = ocol_q;
  assign OUT_R      = opix_q[2];
  assign OUT_G      = opix_q[1];
  assign OUT_B      = opix_q[0];
endmodule
